// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt controller states, register map and cause codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state_t;

  localparam logic [2:0] IRQ_REG_PENDING = 3'd0;
  localparam logic [2:0] IRQ_REG_MASK    = 3'd1;
  localparam logic [2:0] IRQ_REG_CLAIM   = 3'd2;
  localparam logic [2:0] IRQ_REG_SWSET   = 3'd3;
  localparam logic [2:0] IRQ_REG_TRIGGER = 3'd4;
  localparam logic [2:0] IRQ_REG_OVERRUN = 3'd5;

  localparam logic [7:0] CAUSE_EXT_IRQ_BASE = 8'h10;

endpackage

// File: rtl/cpu_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module irq_prio_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any,
  output logic [3:0]       idx
);

  logic [WIDTH-1:0] first;
  logic [3:0]       idx_term [WIDTH];

  // A bit wins only if no lower-indexed bit is set, so at most one term is non-zero.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    localparam logic [WIDTH-1:0] LOWER = WIDTH'((1 << gi) - 1);
    assign first[gi]    = vec[gi] & ~(|(vec & LOWER));
    assign idx_term[gi] = first[gi] ? 4'(gi) : 4'd0;
  end

  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = idx | idx_term[i];
    end
  end

  assign any = |vec;

endmodule

// File: rtl/cpu_irq_ctrl.sv
// CPU interrupt controller: pending/mask/overrun registers, one in-service interrupt, bus register file.
// Optional level-sensitive lines (TRIGGER register) are built when CPU_IRQ_LEVEL_EN is defined.
module cpu_irq_ctrl
  import cpu_pkg::*;
#(
  parameter int         NUM_IRQ    = 8,
  parameter logic [7:0] CAUSE_BASE = CAUSE_EXT_IRQ_BASE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  output logic [7:0]         irq_cause,
  input  logic               irq_ack,
  input  logic               bus_req,
  input  logic               bus_write,
  input  logic [2:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack
);

  irq_state_t         state_reg, state_next;
  logic [3:0]         cur_id_reg, cur_id_next;
  logic [NUM_IRQ-1:0] irq_in_q_reg, pending_reg, pending_next;
  logic [NUM_IRQ-1:0] mask_reg, mask_next, overrun_reg, overrun_next;
  logic               bus_ack_reg;
  logic [31:0]        bus_rdata_reg, bus_rdata_next;
  logic [NUM_IRQ-1:0] level_lines;

`ifdef CPU_IRQ_LEVEL_EN
  logic [NUM_IRQ-1:0] trigger_reg, trigger_next;
  assign level_lines = trigger_reg;
`else
  assign level_lines = '0;
`endif

  logic [NUM_IRQ-1:0] arb_vec;
  logic               arb_any;
  logic [3:0]         arb_idx;

  assign arb_vec = pending_reg & mask_reg;

  irq_prio_enc #(.WIDTH(NUM_IRQ)) u_prio_enc (
    .vec (arb_vec),
    .any (arb_any),
    .idx (arb_idx)
  );

  logic               wr_en, rd_en, ack_take;
  logic [NUM_IRQ-1:0] wdata_bits, rise, w1c_pend, sw_set, w1c_ovr, ack_clr, edge_pend;
  logic               unused_wdata_bits;

  assign unused_wdata_bits = ^bus_wdata[31:NUM_IRQ];
  assign wdata_bits        = bus_wdata[NUM_IRQ-1:0];

  always_comb begin
    state_next     = state_reg;
    cur_id_next    = cur_id_reg;
    mask_next      = mask_reg;
    bus_rdata_next = 32'd0;
`ifdef CPU_IRQ_LEVEL_EN
    trigger_next   = trigger_reg;
`endif

    wr_en    = bus_req & bus_write;
    rd_en    = bus_req & ~bus_write;
    ack_take = (state_reg == IRQ_REQ) && irq_ack;
    rise     = irq_in & ~irq_in_q_reg;
    w1c_pend = (wr_en && bus_addr == IRQ_REG_PENDING) ? wdata_bits : '0;
    sw_set   = (wr_en && bus_addr == IRQ_REG_SWSET)   ? wdata_bits : '0;
    w1c_ovr  = (wr_en && bus_addr == IRQ_REG_OVERRUN) ? wdata_bits : '0;

    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_take && cur_id_reg == 4'(i)) ack_clr[i] = 1'b1;
    end

    // Sets are applied after clears so a same-cycle edge or SWSET wins over W1C/ack.
    edge_pend    = (pending_reg & ~w1c_pend & ~ack_clr) | rise | sw_set;
    pending_next = (edge_pend & ~level_lines) | (irq_in & level_lines);
    overrun_next = (overrun_reg & ~w1c_ovr) | (rise & pending_reg & ~level_lines);

    if (wr_en && bus_addr == IRQ_REG_MASK) mask_next = wdata_bits;
`ifdef CPU_IRQ_LEVEL_EN
    if (wr_en && bus_addr == IRQ_REG_TRIGGER) trigger_next = wdata_bits;
`endif

    unique case (state_reg)
      IRQ_IDLE: begin
        if (arb_any) begin
          cur_id_next = arb_idx;
          state_next  = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        if (irq_ack) state_next = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (wr_en && bus_addr == IRQ_REG_CLAIM) state_next = IRQ_IDLE;
      end
      default: state_next = IRQ_IDLE;
    endcase

    if (rd_en) begin
      case (bus_addr)
        IRQ_REG_PENDING: bus_rdata_next = 32'(pending_reg);
        IRQ_REG_MASK:    bus_rdata_next = 32'(mask_reg);
        IRQ_REG_CLAIM:   bus_rdata_next = {state_reg == IRQ_SERVICE, 27'd0, cur_id_reg};
`ifdef CPU_IRQ_LEVEL_EN
        IRQ_REG_TRIGGER: bus_rdata_next = 32'(trigger_reg);
`endif
        IRQ_REG_OVERRUN: bus_rdata_next = 32'(overrun_reg);
        default:         bus_rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IRQ_IDLE;
      cur_id_reg    <= 4'd0;
      irq_in_q_reg  <= '0;
      pending_reg   <= '0;
      mask_reg      <= '0;
      overrun_reg   <= '0;
      bus_ack_reg   <= 1'b0;
      bus_rdata_reg <= 32'd0;
`ifdef CPU_IRQ_LEVEL_EN
      trigger_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cur_id_reg    <= cur_id_next;
      irq_in_q_reg  <= irq_in;
      pending_reg   <= pending_next;
      mask_reg      <= mask_next;
      overrun_reg   <= overrun_next;
      bus_ack_reg   <= bus_req;
      bus_rdata_reg <= bus_rdata_next;
`ifdef CPU_IRQ_LEVEL_EN
      trigger_reg   <= trigger_next;
`endif
    end
  end

  assign irq       = (state_reg == IRQ_REQ);
  assign irq_cause = irq ? (CAUSE_BASE + {4'd0, cur_id_reg}) : 8'h00;
  assign bus_ack   = bus_ack_reg;
  assign bus_rdata = bus_rdata_reg;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Self-checking bench for cpu_irq_ctrl: per-cycle reference model plus directed literal checks.
module tb_cpu_irq_ctrl;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         irq;
  logic [7:0]   irq_cause;
  logic         irq_ack = 1'b0;
  logic         bus_req = 1'b0;
  logic         bus_write = 1'b0;
  logic [2:0]   bus_addr = 3'd0;
  logic [31:0]  bus_wdata = 32'd0;
  logic [31:0]  bus_rdata;
  logic         bus_ack;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  cpu_irq_ctrl dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .irq(irq), .irq_cause(irq_cause),
    .irq_ack(irq_ack), .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=waiting, 1=requesting, 2=in service.
  bit [N-1:0] m_pend, m_mask, m_ov, m_trig, m_prev, n_pend, n_ov;
  int         m_mode = 0;
  int         m_id = 0;
  bit         e_ack = 0;
  bit [31:0]  e_rdata = 0;
  bit         wr, rdop, rs, clr;

  always @(posedge clock) begin
    if (reset) begin
      m_pend = '0; m_mask = '0; m_ov = '0; m_trig = '0; m_prev = '0;
      m_mode = 0; m_id = 0; e_ack = 0; e_rdata = 0;
    end else begin
      wr = bus_req && bus_write;
      rdop = bus_req && !bus_write;
      e_ack = bus_req;
      e_rdata = 0;
      if (rdop) begin
        case (bus_addr)
          3'd0: e_rdata = {24'd0, m_pend};
          3'd1: e_rdata = {24'd0, m_mask};
          3'd2: e_rdata = (m_mode == 2 ? 32'h8000_0000 : 32'd0) + m_id;
`ifdef CPU_IRQ_LEVEL_EN
          3'd4: e_rdata = {24'd0, m_trig};
`endif
          3'd5: e_rdata = {24'd0, m_ov};
          default: e_rdata = 0;
        endcase
      end
      n_pend = m_pend;
      n_ov = m_ov;
      for (int i = 0; i < N; i++) begin
        rs = (irq_in[i] && !m_prev[i]) || (wr && bus_addr == 3'd3 && bus_wdata[i]);
        clr = (wr && bus_addr == 3'd0 && bus_wdata[i]) || (m_mode == 1 && irq_ack && m_id == i);
        if (m_trig[i]) n_pend[i] = irq_in[i];
        else if (rs) n_pend[i] = 1;
        else if (clr) n_pend[i] = 0;
        if (!m_trig[i] && irq_in[i] && !m_prev[i] && m_pend[i]) n_ov[i] = 1;
        else if (wr && bus_addr == 3'd5 && bus_wdata[i]) n_ov[i] = 0;
      end
      if (m_mode == 0) begin
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) begin m_id = i; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (irq_ack) m_mode = 2;
      end else if (wr && bus_addr == 3'd2) begin
        m_mode = 0;
      end
      if (wr && bus_addr == 3'd1) m_mask = bus_wdata[N-1:0];
`ifdef CPU_IRQ_LEVEL_EN
      if (wr && bus_addr == 3'd4) m_trig = bus_wdata[N-1:0];
`endif
      m_pend = n_pend;
      m_ov = n_ov;
      m_prev = irq_in;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_irq", {31'd0, irq}, {31'd0, m_mode == 1});
      check("model_cause", {24'd0, irq_cause}, (m_mode == 1) ? 32'h10 + m_id : 32'd0);
      check("model_bus_ack", {31'd0, bus_ack}, {31'd0, e_ack});
      check("model_rdata", bus_rdata, e_rdata);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus_req = 1; bus_write = 1; bus_addr = a; bus_wdata = d;
    @(negedge clock);
    bus_req = 0; bus_write = 0; bus_wdata = 0;
    $display("bus write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus_req = 1; bus_write = 0; bus_addr = a;
    @(negedge clock);
    bus_req = 0;
    $display("bus read  addr=%0d data=%h", a, bus_rdata);
    check(name, bus_rdata, exp);
  endtask

  task automatic pulse(input int i);
    irq_in[i] = 1'b1;
    @(negedge clock);
    irq_in[i] = 1'b0;
    $display("pulse irq_in[%0d]", i);
  endtask

  task automatic do_ack();
    irq_ack = 1;
    @(negedge clock);
    irq_ack = 0;
    $display("irq_ack pulse");
  endtask

  task automatic chk_irq(input logic e_irq, input logic [7:0] e_cause, input string name);
    $display("irq=%0d cause=%h", irq, irq_cause);
    check({name, "_irq"}, {31'd0, irq}, {31'd0, e_irq});
    check({name, "_cause"}, {24'd0, irq_cause}, {24'd0, e_cause});
  endtask

  initial begin
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    chk_irq(0, 8'h00, "reset");
    bus_rd(3'd0, 32'h0, "reset_pending");
    bus_rd(3'd1, 32'h0, "reset_mask");
    bus_rd(3'd2, 32'h0, "reset_claim");
    bus_rd(3'd5, 32'h0, "reset_overrun");

    // Priority: line 2 beats line 3 once both are pending and unmasked.
    pulse(3); tick(); pulse(2);
    bus_wr(3'd1, 32'h0C);
    chk_irq(0, 8'h00, "t1_pre");
    tick();
    chk_irq(1, 8'h12, "t1_req");
    tick();
    chk_irq(1, 8'h12, "t1_hold");
    do_ack();
    chk_irq(0, 8'h00, "t1_svc");
    bus_rd(3'd0, 32'h08, "t1_pending");
    bus_rd(3'd2, 32'h8000_0002, "t1_claim");
    bus_wr(3'd2, 32'h0);
    tick();
    chk_irq(1, 8'h13, "t1_rearb");
    do_ack();
    bus_wr(3'd2, 32'h0);

    // Masked request waits; unmask raises irq two cycles after the write strobe.
    bus_wr(3'd1, 32'h0);
    pulse(5);
    bus_rd(3'd0, 32'h20, "t2_pending");
    chk_irq(0, 8'h00, "t2_masked");
    bus_wr(3'd1, 32'h20);
    chk_irq(0, 8'h00, "t2_one_cycle");
    tick();
    chk_irq(1, 8'h15, "t2_two_cycle");
    do_ack();
    bus_wr(3'd2, 32'h0);

    // Overrun on a second edge while still pending.
    pulse(1); tick(); pulse(1);
    bus_rd(3'd0, 32'h02, "t3_pending");
    bus_rd(3'd5, 32'h02, "t3_overrun");
    bus_wr(3'd5, 32'h02);
    bus_rd(3'd5, 32'h00, "t3_overrun_clr");
    bus_wr(3'd0, 32'h02);
    bus_rd(3'd0, 32'h00, "t3_pending_clr");

    // Clearing pending during REQ does not withdraw the request.
    bus_wr(3'd1, 32'h01);
    pulse(0);
    tick();
    chk_irq(1, 8'h10, "t4_req");
    bus_wr(3'd0, 32'h01);
    chk_irq(1, 8'h10, "t4_after_w1c");
    bus_rd(3'd0, 32'h00, "t4_pending");
    bus_wr(3'd2, 32'h0);
    chk_irq(1, 8'h10, "t4_eoi_ignored");
    do_ack();
    bus_rd(3'd2, 32'h8000_0000, "t4_claim");
    do_ack();
    bus_wr(3'd2, 32'h0);

    // An edge in the same cycle as W1C of that bit keeps it set; SWSET sets bits.
    irq_in[7] = 1;
    bus_wr(3'd0, 32'h80);
    irq_in[7] = 0;
    bus_rd(3'd0, 32'h80, "t5_set_beats_clear");
    bus_wr(3'd3, 32'h40);
    bus_rd(3'd0, 32'hC0, "t5_swset");
    bus_wr(3'd4, 32'hFF);
    bus_rd(3'd6, 32'h0, "t5_unused_addr");
    bus_wr(3'd1, 32'hC0);
    tick();
    chk_irq(1, 8'h16, "t5_req");
    reset = 1;
    tick();
    reset = 0;
    chk_irq(0, 8'h00, "t5_reset");
    bus_rd(3'd0, 32'h0, "t5_rst_pending");
    bus_rd(3'd1, 32'h0, "t5_rst_mask");
    bus_rd(3'd2, 32'h0, "t5_rst_claim");
    bus_rd(3'd4, 32'h0, "t5_rst_trigger");
    tick();
    chk_irq(0, 8'h00, "t5_idle");

`ifdef CPU_IRQ_LEVEL_EN
    // Level line: ack leaves it pending, W1C has no lasting effect.
    bus_wr(3'd4, 32'h01);
    bus_rd(3'd4, 32'h01, "t6_trigger");
    bus_wr(3'd1, 32'h01);
    irq_in[0] = 1;
    tick(); tick();
    chk_irq(1, 8'h10, "t6_req");
    do_ack();
    bus_rd(3'd0, 32'h01, "t6_pending_after_ack");
    bus_wr(3'd0, 32'h01);
    bus_rd(3'd0, 32'h01, "t6_w1c_no_effect");
    irq_in[0] = 0;
    tick();
    bus_wr(3'd2, 32'h0);
    bus_rd(3'd2, 32'h0, "t6_claim_idle");
    tick();
    chk_irq(0, 8'h00, "t6_idle");
`else
    bus_rd(3'd4, 32'h0, "t6_trigger_absent");
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
